// File: rtl/dmem_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder_pkg
// Description : Shared types and helpers for the data-memory responder.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_responder_pkg;

    typedef logic [31:0] word_t;

    typedef struct packed {
        word_t      addr;
        word_t      data;
        logic [3:0] mask;
    } sb_entry_t;

    typedef enum logic [1:0] {
        DM_IDLE   = 2'd0,
        DM_DRAIN  = 2'd1,
        DM_RD_REQ = 2'd2,
        DM_RD_RSP = 2'd3
    } dmem_state_t;

    // Byte offset bits are ignored; every access is to a whole word.
    function automatic word_t word_align(input word_t addr);
        return addr & ~word_t'(3);
    endfunction

endpackage : dmem_responder_pkg
`default_nettype wire

// File: rtl/dmem_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder_if
// Description : CPU data port plus backing-memory handshake of the responder.
// Revision    : 1.0 - initial release
// ============================================================================
interface dmem_responder_if;
    import dmem_responder_pkg::*;

    // CPU side
    word_t      dmem_addr_i;
    logic       dmem_read_enable_i;
    word_t      dmem_write_data_i;
    logic [3:0] dmem_write_mask_i;
    word_t      dmem_read_data_o;
    logic       dmem_read_valid_o;
    logic       stall_o;

    // Backing-memory side
    logic       mem_req_o;
    logic       mem_we_o;
    word_t      mem_addr_o;
    word_t      mem_wdata_o;
    logic [3:0] mem_wmask_o;
    logic       mem_ack_i;
    word_t      mem_rdata_i;

    modport slave (
        input  dmem_addr_i, dmem_read_enable_i, dmem_write_data_i, dmem_write_mask_i,
        output dmem_read_data_o, dmem_read_valid_o, stall_o,
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wmask_o,
        input  mem_ack_i, mem_rdata_i
    );

    modport master (
        output dmem_addr_i, dmem_read_enable_i, dmem_write_data_i, dmem_write_mask_i,
        input  dmem_read_data_o, dmem_read_valid_o, stall_o,
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wmask_o,
        output mem_ack_i, mem_rdata_i
    );

endinterface : dmem_responder_if
`default_nettype wire

// File: rtl/dmem_responder_store_buffer.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder_store_buffer
// Description : FIFO of posted writes awaiting drain to backing memory.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder_store_buffer
    import dmem_responder_pkg::*;
#(
    parameter int unsigned SB_DEPTH = 4
) (
    input  wire logic                      clk_i,
    input  wire logic                      reset_i,
    input  wire logic                      i_push,
    input  wire sb_entry_t                 i_push_entry,
    input  wire logic                      i_pop,
    output sb_entry_t                      o_head,
    output logic                           o_full,
    output logic                           o_empty,
    output logic [$clog2(SB_DEPTH):0]      o_count
);

    localparam int unsigned PTR_W = $clog2(SB_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] c_full_count = CNT_W'(SB_DEPTH);

    sb_entry_t        r_mem [SB_DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    // Guard against overflow/underflow even if the caller misbehaves.
    assign w_push = i_push && (r_count != c_full_count);
    assign w_pop  = i_pop  && (r_count != '0);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + 1'b1;
            end
            if (w_pop) begin
                r_head <= r_head + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: only slots between head and tail are ever observed.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_tail] <= i_push_entry;
        end
    end

    assign o_head  = r_mem[r_head];
    assign o_full  = (r_count == c_full_count);
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule : dmem_responder_store_buffer
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder
// Description : CPU data-memory responder with posted-write store buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int unsigned SB_DEPTH = 4
) (
    input  wire logic         clk_i,
    input  wire logic         reset_i,
    dmem_responder_if.slave   bus
);

    localparam int unsigned CNT_W = $clog2(SB_DEPTH) + 1;

    dmem_state_t      r_state;
    dmem_state_t      w_state_next;
    word_t            r_rd_addr;
    word_t            r_rd_data;
    sb_entry_t        w_head;
    sb_entry_t        w_push_entry;
    logic             w_sb_full;
    logic             w_sb_empty;
    logic [CNT_W-1:0] w_sb_count;
    logic             w_rd_req;
    logic             w_wr_req;
    logic             w_push;
    logic             w_pop;

    // A read suppresses any simultaneous write mask.
    assign w_rd_req = bus.dmem_read_enable_i;
    assign w_wr_req = (bus.dmem_write_mask_i != 4'b0000) && !bus.dmem_read_enable_i;
    assign w_push   = w_wr_req && !w_sb_full;
    assign w_pop    = (r_state == DM_DRAIN) && bus.mem_ack_i;

    assign w_push_entry = '{
        addr: word_align(bus.dmem_addr_i),
        data: bus.dmem_write_data_i,
        mask: bus.dmem_write_mask_i
    };

    dmem_responder_store_buffer #(
        .SB_DEPTH (SB_DEPTH)
    ) u_store_buffer (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .i_push       (w_push),
        .i_push_entry (w_push_entry),
        .i_pop        (w_pop),
        .o_head       (w_head),
        .o_full       (w_sb_full),
        .o_empty      (w_sb_empty),
        .o_count      (w_sb_count)
    );

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state <= DM_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Draining always wins over starting a read, which preserves RAW order.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            DM_IDLE: begin
                if (!w_sb_empty) begin
                    w_state_next = DM_DRAIN;
                end else if (w_rd_req && (w_sb_count == '0)) begin
                    w_state_next = DM_RD_REQ;
                end
            end
            DM_DRAIN: begin
                if (bus.mem_ack_i) begin
                    w_state_next = DM_IDLE;
                end
            end
            DM_RD_REQ: begin
                if (bus.mem_ack_i) begin
                    w_state_next = DM_RD_RSP;
                end
            end
            DM_RD_RSP: begin
                w_state_next = DM_IDLE;
            end
            default: begin
                w_state_next = DM_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_rd_addr <= '0;
            r_rd_data <= '0;
        end else begin
            if ((r_state == DM_IDLE) && (w_state_next == DM_RD_REQ)) begin
                r_rd_addr <= word_align(bus.dmem_addr_i);
            end
            if ((r_state == DM_RD_REQ) && bus.mem_ack_i) begin
                r_rd_data <= bus.mem_rdata_i;
            end
        end
    end

    always_comb begin
        bus.mem_req_o   = 1'b0;
        bus.mem_we_o    = 1'b0;
        bus.mem_addr_o  = '0;
        bus.mem_wdata_o = '0;
        bus.mem_wmask_o = 4'b0000;
        case (r_state)
            DM_DRAIN: begin
                bus.mem_req_o   = 1'b1;
                bus.mem_we_o    = 1'b1;
                bus.mem_addr_o  = w_head.addr;
                bus.mem_wdata_o = w_head.data;
                bus.mem_wmask_o = w_head.mask;
            end
            DM_RD_REQ: begin
                bus.mem_req_o  = 1'b1;
                bus.mem_addr_o = r_rd_addr;
            end
            default: begin
                bus.mem_req_o = 1'b0;
            end
        endcase
    end

    // A read holds the CPU until the response cycle; a write only when the buffer is full.
    assign bus.stall_o           = (w_rd_req && (r_state != DM_RD_RSP)) || (w_wr_req && w_sb_full);
    assign bus.dmem_read_valid_o = (r_state == DM_RD_RSP);
    assign bus.dmem_read_data_o  = r_rd_data;

    a_rd_wr_exclusive: assert property (
        @(posedge clk_i) disable iff (reset_i)
        !(bus.dmem_read_enable_i && (bus.dmem_write_mask_i != 4'b0000))
    );

endmodule : dmem_responder
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_responder
// Description : Randomized self-checking bench with backing-memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;
    import dmem_responder_pkg::*;

    localparam int unsigned SB_DEPTH = 4;

    typedef struct {
        bit         we;
        word_t      addr;
        word_t      data;
        logic [3:0] mask;
        int         edge_cyc;
    } txn_t;

    logic clk_i   = 1'b0;
    logic reset_i = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   proto_err = 0;
    bit   ack_hold  = 1'b0;
    int   ack_delay = 0;

    word_t backing_mem [word_t];
    word_t model_mem   [word_t];
    txn_t  log_q [$];

    dmem_responder_if bus ();

    dmem_responder #(.SB_DEPTH(SB_DEPTH)) dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .bus     (bus)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    function automatic word_t align(input word_t a);
        return a & 32'hFFFF_FFFC;
    endfunction

    function automatic word_t init_val(input word_t a);
        return {a[15:0], ~a[15:0]};
    endfunction

    function automatic word_t merge(input word_t old, input word_t d, input logic [3:0] m);
        word_t r = old;
        for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    function automatic word_t backing_read(input word_t a);
        return backing_mem.exists(a) ? backing_mem[a] : init_val(a);
    endfunction

    function automatic word_t model_read(input word_t a);
        return model_mem.exists(a) ? model_mem[a] : init_val(a);
    endfunction

    // Backing memory: decides ack mid-cycle, logs the transaction taken at the next edge.
    initial begin : mem_model
        int wait_cnt;
        bit prev_ack, prev_req, prev_we;
        word_t prev_addr, prev_wdata;
        logic [3:0] prev_mask;
        txn_t t;
        wait_cnt = 0; prev_ack = 0; prev_req = 0; prev_we = 0;
        prev_addr = '0; prev_wdata = '0; prev_mask = '0;
        bus.mem_ack_i = 1'b0;
        bus.mem_rdata_i = '0;
        forever begin
            @(negedge clk_i);
            if (reset_i) begin
                bus.mem_ack_i = 1'b0; wait_cnt = 0; prev_ack = 0; prev_req = 0;
            end else begin
                if (bus.mem_req_o) begin
                    if (prev_ack) proto_err++;
                    if (prev_req && !prev_ack && (bus.mem_addr_o !== prev_addr || bus.mem_wdata_o !== prev_wdata ||
                        bus.mem_wmask_o !== prev_mask || bus.mem_we_o !== prev_we)) proto_err++;
                    if (!ack_hold && wait_cnt >= ack_delay) begin
                        bus.mem_ack_i = 1'b1;
                        if (bus.mem_we_o) backing_mem[bus.mem_addr_o] = merge(backing_read(bus.mem_addr_o), bus.mem_wdata_o, bus.mem_wmask_o);
                        else bus.mem_rdata_i = backing_read(bus.mem_addr_o);
                        t.we = bus.mem_we_o; t.addr = bus.mem_addr_o; t.data = bus.mem_wdata_o;
                        t.mask = bus.mem_wmask_o; t.edge_cyc = cyc + 1;
                        log_q.push_back(t);
                        wait_cnt = 0;
                    end else begin
                        bus.mem_ack_i = 1'b0; wait_cnt++;
                    end
                end else begin
                    bus.mem_ack_i = 1'b0; wait_cnt = 0;
                end
                prev_ack = bus.mem_ack_i; prev_req = bus.mem_req_o; prev_we = bus.mem_we_o;
                prev_addr = bus.mem_addr_o; prev_wdata = bus.mem_wdata_o; prev_mask = bus.mem_wmask_o;
            end
        end
    end

    // CPU drivers: entered and left just after a rising edge.
    task automatic cpu_write(input word_t a, input word_t d, input logic [3:0] m,
                             output bit first_stall, output int acc_cyc, output bit ok);
        bus.dmem_addr_i = a; bus.dmem_write_data_i = d; bus.dmem_write_mask_i = m;
        bus.dmem_read_enable_i = 1'b0;
        ok = 0; first_stall = 0; acc_cyc = -1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk_i);
            if (k == 0) first_stall = bus.stall_o;
            if (!bus.stall_o) begin ok = 1; acc_cyc = cyc + 1; break; end
        end
        if (ok) model_mem[align(a)] = merge(model_read(align(a)), d, m);
        @(posedge clk_i); #1;
        bus.dmem_write_mask_i = 4'b0000;
    endtask

    task automatic cpu_read(input word_t a, output word_t d, output int stall_cyc, output bit ok);
        bus.dmem_addr_i = a; bus.dmem_read_enable_i = 1'b1; bus.dmem_write_mask_i = 4'b0000;
        ok = 0; stall_cyc = 0; d = '0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk_i);
            if (!bus.stall_o) begin ok = bus.dmem_read_valid_o; d = bus.dmem_read_data_o; break; end
            stall_cyc++;
        end
        @(posedge clk_i); #1;
        bus.dmem_read_enable_i = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        bit fs, ok; int ac, n0, req_seen;
        #12;
        n_tests++; if (bus.mem_req_o !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", bus.mem_req_o); end
        n_tests++; if (bus.stall_o !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", bus.stall_o); end
        n_tests++; if (bus.dmem_read_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bus.dmem_read_valid_o); end
        n_tests++; if (bus.dmem_read_data_o !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", bus.dmem_read_data_o); end
        n_tests++; if ({bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o, bus.mem_wmask_o} !== 69'h0) begin
            n_fail++; $display("FAIL reset_mem_bus: got we=%b a=%h d=%h m=%h want all 0", bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o, bus.mem_wmask_o); end
        @(posedge clk_i); #1 reset_i = 1'b0;
        // Start a drain that never gets acked, then reset in the middle of it.
        ack_hold = 1'b1;
        cpu_write(32'h0000_0800, 32'hCAFE_F00D, 4'hF, fs, ac, ok);
        req_seen = 0;
        for (int k = 0; k < 6 && !req_seen; k++) begin @(negedge clk_i); req_seen = bus.mem_req_o; end
        n_tests++; if (req_seen !== 1) begin n_fail++; $display("FAIL drain_start: got req=%0d want 1", req_seen); end
        @(posedge clk_i); #3 reset_i = 1'b1;
        #1;
        n_tests++; if (bus.mem_req_o !== 1'b0) begin n_fail++; $display("FAIL reset_async_req: got %b want 0", bus.mem_req_o); end
        model_mem = backing_mem;
        idle(2);
        reset_i = 1'b0;
        ack_hold = 1'b0; ack_delay = 0;
        n0 = log_q.size(); req_seen = 0;
        for (int k = 0; k < 10; k++) begin @(negedge clk_i); if (bus.mem_req_o) req_seen++; end
        n_tests++; if (req_seen !== 0 || log_q.size() !== n0) begin
            n_fail++; $display("FAIL reset_discard: got req_cycles=%0d new_txns=%0d want 0/0", req_seen, log_q.size() - n0); end
        @(posedge clk_i); #1;
    endtask

    task automatic test_single_write();
        bit fs, ok; int ac, n0;
        ack_delay = 2; n0 = log_q.size();
        cpu_write(32'h0000_1000, 32'hDEAD_BEEF, 4'hF, fs, ac, ok);
        n_tests++; if (fs !== 0 || ok !== 1) begin n_fail++; $display("FAIL single_wr_stall: got stall=%b ok=%b want 0/1", fs, ok); end
        for (int k = 0; k < 20 && log_q.size() == n0; k++) @(negedge clk_i);
        n_tests++;
        if (log_q.size() <= n0) begin n_fail++; $display("FAIL single_wr_txn: got none want 1"); end
        else if (log_q[n0].we !== 1 || log_q[n0].addr !== 32'h1000 || log_q[n0].data !== 32'hDEAD_BEEF || log_q[n0].mask !== 4'hF) begin
            n_fail++; $display("FAIL single_wr_txn: got we=%b a=%h d=%h m=%h want 1/00001000/deadbeef/f",
                               log_q[n0].we, log_q[n0].addr, log_q[n0].data, log_q[n0].mask); end
        idle(10);
    endtask

    task automatic test_sb_full();
        word_t a [5]; word_t d [5]; logic [3:0] m [5];
        bit fs, ok, fs5, ok5; int ac, ac5, n0, stalls;
        for (int i = 0; i < 5; i++) begin a[i] = 32'h100 + 32'(4*i); d[i] = $urandom; m[i] = 4'(1 << (i % 4)); end
        ack_hold = 1'b1; ack_delay = 0; n0 = log_q.size(); stalls = 0;
        for (int i = 0; i < 4; i++) begin cpu_write(a[i], d[i], m[i], fs, ac, ok); stalls += int'(fs); end
        n_tests++; if (stalls !== 0) begin n_fail++; $display("FAIL sb_fill_stall: got %0d stalls want 0", stalls); end
        fork
            cpu_write(a[4], d[4], m[4], fs5, ac5, ok5);
            begin repeat (3) @(posedge clk_i); #2 ack_hold = 1'b0; end
        join
        n_tests++; if (fs5 !== 1 || ok5 !== 1) begin n_fail++; $display("FAIL sb_full_stall: got stall=%b ok=%b want 1/1", fs5, ok5); end
        for (int k = 0; k < 60 && log_q.size() < n0 + 5; k++) @(negedge clk_i);
        n_tests++;
        if (log_q.size() < n0 + 5) begin n_fail++; $display("FAIL sb_drain_count: got %0d want 5", log_q.size() - n0); end
        else begin
            if (ac5 !== log_q[n0].edge_cyc + 1) begin n_fail++; $display("FAIL sb_accept_after_ack: got %0d want %0d", ac5, log_q[n0].edge_cyc + 1); end
            for (int i = 0; i < 5; i++) begin
                n_tests++;
                if (log_q[n0+i].addr !== a[i] || log_q[n0+i].data !== d[i] || log_q[n0+i].mask !== m[i] || log_q[n0+i].we !== 1) begin
                    n_fail++; $display("FAIL sb_order[%0d]: got a=%h d=%h m=%h want a=%h d=%h m=%h", i,
                                       log_q[n0+i].addr, log_q[n0+i].data, log_q[n0+i].mask, a[i], d[i], m[i]); end
            end
        end
        idle(10);
    endtask

    task automatic test_raw();
        bit fs, ok; int ac, n0, sc; word_t d, exp;
        ack_delay = 1; n0 = log_q.size();
        cpu_write(32'h2004, 32'h0000_AB00, 4'b0010, fs, ac, ok);
        exp = model_read(32'h2004);
        cpu_read(32'h2004, d, sc, ok);
        n_tests++; if (ok !== 1 || d !== exp) begin n_fail++; $display("FAIL raw_data: got ok=%b d=%h want 1/%h", ok, d, exp); end
        n_tests++;
        if (log_q.size() < n0 + 2) begin n_fail++; $display("FAIL raw_order: got %0d txns want 2", log_q.size() - n0); end
        else if (log_q[n0].we !== 1 || log_q[n0+1].we !== 0 || log_q[n0+1].addr !== 32'h2004 || log_q[n0].edge_cyc >= log_q[n0+1].edge_cyc) begin
            n_fail++; $display("FAIL raw_order: got first_we=%b second_we=%b second_a=%h want 1/0/00002004",
                               log_q[n0].we, log_q[n0+1].we, log_q[n0+1].addr); end
        idle(4);
    endtask

    task automatic test_read_latency();
        bit ok; int sc, bad; word_t d;
        ack_delay = 0;
        backing_mem[32'h4000] = 32'h1234_5678; model_mem[32'h4000] = 32'h1234_5678;
        cpu_read(32'h4000, d, sc, ok);
        n_tests++; if (sc !== 2) begin n_fail++; $display("FAIL rd_latency: got %0d stall cycles want 2", sc); end
        n_tests++; if (ok !== 1 || d !== 32'h1234_5678) begin n_fail++; $display("FAIL rd_data: got ok=%b d=%h want 1/12345678", ok, d); end
        bad = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            if (bus.dmem_read_valid_o !== 1'b0 || bus.dmem_read_data_o !== 32'h1234_5678) bad++;
        end
        n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL rd_hold: got %0d bad cycles want 0", bad); end
        @(posedge clk_i); #1;
    endtask

    task automatic test_read_align();
        bit ok; int sc, n0; word_t d, exp;
        ack_delay = 1; n0 = log_q.size(); exp = model_read(32'h3000);
        cpu_read(32'h3003, d, sc, ok);
        n_tests++;
        if (log_q.size() <= n0) begin n_fail++; $display("FAIL rd_align: got no txn want 1"); end
        else if (log_q[n0].addr !== 32'h3000 || log_q[n0].mask !== 4'h0 || log_q[n0].we !== 0) begin
            n_fail++; $display("FAIL rd_align: got a=%h m=%h we=%b want 00003000/0/0", log_q[n0].addr, log_q[n0].mask, log_q[n0].we); end
        n_tests++; if (ok !== 1 || d !== exp) begin n_fail++; $display("FAIL rd_align_data: got ok=%b d=%h want 1/%h", ok, d, exp); end
        idle(2);
    endtask

    task automatic test_random();
        bit fs, ok; int ac, sc; word_t a, d, exp; logic [3:0] m;
        for (int it = 0; it < 150; it++) begin
            ack_delay = $urandom_range(0, 3);
            a = 32'h5000 + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 2) == 0) begin
                exp = model_read(align(a));
                cpu_read(a, d, sc, ok);
                n_tests++; if (ok !== 1 || d !== exp) begin n_fail++; $display("FAIL rand_read[%0d]: a=%h got ok=%b d=%h want 1/%h", it, a, ok, d, exp); end
            end else begin
                d = $urandom; m = 4'($urandom_range(1, 15));
                cpu_write(a, d, m, fs, ac, ok);
                n_tests++; if (ok !== 1) begin n_fail++; $display("FAIL rand_write[%0d]: a=%h got ok=%b want 1", it, a, ok); end
            end
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        idle(40);
        for (int i = 0; i < 8; i++) begin
            a = 32'h5000 + 32'(4 * i);
            n_tests++; if (backing_read(a) !== model_read(a)) begin n_fail++; $display("FAIL rand_final[%h]: got %h want %h", a, backing_read(a), model_read(a)); end
        end
        n_tests++; if (proto_err !== 0) begin n_fail++; $display("FAIL handshake_protocol: got %0d violations want 0", proto_err); end
    endtask

    initial begin
        bus.dmem_addr_i = '0; bus.dmem_read_enable_i = 1'b0;
        bus.dmem_write_data_i = '0; bus.dmem_write_mask_i = 4'b0000;
        test_reset();
        test_single_write();
        test_sb_full();
        test_raw();
        test_read_latency();
        test_read_align();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d failed so far", n_fail);
        $fatal(1, "watchdog");
    end

endmodule : tb_dmem_responder
`default_nettype wire
